// File: rtl/vga_pkg.sv
// Shared definitions for the VGA name table path.
//   NAME_ADDR_WIDTH / NAME_DATA_WIDTH : name table RAM geometry
//   tag_t : which requester owns the RAM read issued in a given cycle
package vga_pkg;

  localparam int NAME_ADDR_WIDTH = 11;
  localparam int NAME_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    TAG_IDLE = 2'd0,
    TAG_DISP = 2'd1,
    TAG_HOST = 2'd2
  } tag_t;

endpackage

// File: rtl/name_ram_arbiter.sv
// Shares the one-cycle registered read port of the name table RAM between
// the display tile fetcher (fixed priority, no handshake) and a host/debug
// reader (req/ack handshake, served in idle cycles).
//
// Ports:
//   clk, rst_n             pixel clock, async active-low reset
//   disp_req, disp_addr    display read request (single cycle)
//   disp_valid, disp_data  display read data, one cycle after the request
//   host_req, host_addr    host request level and address
//   host_ack               pulse in the cycle the host read is issued
//   host_valid, host_data  pulse when host_data updates; data held after
//   host_starve            host has waited STARVE_LIMIT cycles (status only)
//   ram_addr, ram_rdata    name table RAM address out / read data in
//
// Handshake: host_req is a level held with host_addr stable until host_ack.
// host_ack is the single cycle in which the read is issued; keeping
// host_req high after that cycle is a new request. Dropping host_req
// before host_ack abandons the request. The display side has no
// handshake: disp_req is always granted in the cycle it is asserted.
module name_ram_arbiter
  import vga_pkg::*;
#(
  parameter int ADDR_WIDTH   = NAME_ADDR_WIDTH,
  parameter int DATA_WIDTH   = NAME_DATA_WIDTH,
  parameter int STARVE_LIMIT = 800,
  parameter int CNT_WIDTH    = $clog2(STARVE_LIMIT + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  disp_req,
  input  logic [ADDR_WIDTH-1:0] disp_addr,
  output logic                  disp_valid,
  output logic [DATA_WIDTH-1:0] disp_data,
  input  logic                  host_req,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  output logic                  host_ack,
  output logic                  host_valid,
  output logic [DATA_WIDTH-1:0] host_data,
  output logic                  host_starve,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  localparam logic [CNT_WIDTH-1:0] LIMIT = CNT_WIDTH'(STARVE_LIMIT);

  tag_t                  grant;
  tag_t                  tag_q;
  logic [ADDR_WIDTH-1:0] last_addr_q;
  logic [CNT_WIDTH-1:0]  wait_cnt_q;
  logic [CNT_WIDTH-1:0]  wait_cnt_d;
  logic                  starve_clr;

  // Grant and address mux. With no grant the RAM keeps seeing the last
  // address so its address bus stays quiet in idle cycles.
  always_comb begin
    grant    = TAG_IDLE;
    ram_addr = last_addr_q;
    host_ack = 1'b0;
    if (disp_req) begin
      grant    = TAG_DISP;
      ram_addr = disp_addr;
    end else if (host_req) begin
      grant    = TAG_HOST;
      ram_addr = host_addr;
      host_ack = 1'b1;
    end
  end

  // Wait counter: counts ungranted host cycles, saturates at the limit,
  // and restarts whenever the host is served or withdraws.
  always_comb begin
    starve_clr = !host_req || (grant == TAG_HOST);
    wait_cnt_d = wait_cnt_q;
    if (starve_clr) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != LIMIT) begin
      wait_cnt_d = wait_cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q       <= TAG_IDLE;
      last_addr_q <= '0;
      host_valid  <= 1'b0;
      host_data   <= '0;
      wait_cnt_q  <= '0;
      host_starve <= 1'b0;
    end else begin
      tag_q <= grant;
      if (grant != TAG_IDLE) begin
        last_addr_q <= ram_addr;
      end
      // The RAM answers a host read one cycle after issue; capture it then
      // so host_valid lands two cycles after host_ack.
      host_valid <= (tag_q == TAG_HOST);
      if (tag_q == TAG_HOST) begin
        host_data <= ram_rdata;
      end
      wait_cnt_q  <= wait_cnt_d;
      // Flag follows the registered count, and drops in the same edge that
      // clears the count.
      host_starve <= !starve_clr && (wait_cnt_q == LIMIT);
    end
  end

  // Display data is a straight passthrough so its latency matches a direct
  // RAM connection; only the valid needs the issued tag.
  assign disp_valid = (tag_q == TAG_DISP);
  assign disp_data  = ram_rdata;

endmodule

// File: doc/name_ram_arbiter.md
Name: name_ram_arbiter

Overview:
Shares the single synchronous read port of the name table RAM (11-bit address, 8-bit data, one-cycle registered read) between two requesters. The first is the VGA display tile fetcher, which has fixed priority because pixel timing cannot stall. The second is a host/debug reader, which uses a req/ack handshake and is served in idle cycles. The block sits directly in front of the name table RAM, routes read data back to the requester that issued the read, and flags host starvation.

Parameters:
ADDR_WIDTH, 11, name table address width
DATA_WIDTH, 8, name table data width
STARVE_LIMIT, 800, host wait cycles (one 800-clock VGA line) before host_starve asserts
CNT_WIDTH, $clog2(STARVE_LIMIT+1), width of the wait counter

Ports:
clk  in  1  pixel clock, rising edge
rst_n  in  1  asynchronous, active-low reset
disp_req  in  1  display read request this cycle (single-cycle, no handshake)
disp_addr  in  ADDR_WIDTH  display read address
disp_valid  out  1  display read data valid
disp_data  out  DATA_WIDTH  display read data
host_req  in  1  host request, level; held high until host_ack
host_addr  in  ADDR_WIDTH  host address; stable while host_req is high
host_ack  out  1  one-cycle pulse in the cycle the host read is issued
host_valid  out  1  one-cycle pulse when host_data updates
host_data  out  DATA_WIDTH  last host read result, held
host_starve  out  1  host has waited STARVE_LIMIT cycles
ram_addr  out  ADDR_WIDTH  to name table RAM addr
ram_rdata  in  DATA_WIDTH  from name table RAM rdata

Behaviour:
- Reset (async, rst_n low): disp_valid=0, host_ack=0, host_valid=0, host_data=0, host_starve=0, wait counter=0, issued-tag=IDLE, last-address register=0.
- Grant per cycle N, combinational:
  - disp_req=1 → grant DISP.
  - else host_req=1 → grant HOST.
  - else no grant.
- ram_addr (combinational mux):
  - disp_addr when DISP is granted.
  - host_addr when HOST is granted.
  - otherwise the last-address register, so the RAM address does not toggle in idle cycles.
  - The last-address register loads the granted address on every grant.
- host_ack = 1 combinationally in a HOST grant cycle only.
- Issued-tag register (IDLE/DISP/HOST) captures the grant at the end of cycle N.
- Return path in cycle N+1:
  - Tag DISP: disp_valid=1 and disp_data=ram_rdata (passthrough). Display latency is 1 cycle, matching a direct RAM connection.
  - Tag HOST: ram_rdata is registered into host_data at the end of N+1; host_valid=1 in cycle N+2. Host latency is 2 cycles from ack.
  - disp_valid=0 otherwise; disp_data is don't-care when disp_valid=0 and equals ram_rdata.
- Back-to-back:
  - The host may keep host_req high after ack; this is a new request, eligible in the next cycle.
  - Continuous disp_req gives continuous DISP grants and disp_valid high every cycle.
- Simultaneous disp_req and host_req: DISP wins; host_ack=0; the host request stays pending.
- Starvation counter:
  - Increments each cycle host_req=1 and HOST is not granted.
  - Saturates at STARVE_LIMIT.
  - Clears to 0 on a HOST grant or when host_req=0.
  - host_starve is registered: 1 when the counter equals STARVE_LIMIT, cleared with the counter.
  - Priority never changes because of starvation; the flag is status only.
- Host dropping host_req before ack abandons the request: no ack, no data.
- Reset mid-read: an in-flight tag is discarded; no valid pulse follows reset release.

Decomposition:
- Shared package (vga_pkg): grant tag encoding TAG_IDLE=2'd0, TAG_DISP=2'd1, TAG_HOST=2'd2, plus NAME_ADDR_WIDTH=11 and NAME_DATA_WIDTH=8.
- No sub-module is required; the block is a grant mux, tag pipeline, host data register and saturating counter.
- The bench instantiates name_ram behind this block, using a known .mem file where address a holds a[7:0].

Test Plan:
- Display only: disp_req=1 with disp_addr=0x005 in cycle 0 → ram_addr=0x005 in cycle 0; disp_valid=1 and disp_data=0x05 in cycle 1; host_ack never asserts.
- Host only: host_req=1 with host_addr=0x1A3, no disp_req → host_ack=1 in cycle 0; host_valid=1 and host_data=0xA3 in cycle 2; host_data stays 0xA3 afterwards.
- Collision: disp_req and host_req both high for 3 cycles, then disp_req low → host_ack=0 for cycles 0–2; host_ack=1 in cycle 3; 3 disp_valid pulses with the correct data.
- Starvation (STARVE_LIMIT=4 override): host_req held with disp_req high for 6 cycles → host_starve=1 from cycle 5; drop disp_req → host_ack, then host_starve=0 on the next cycle.
- Idle hold: after a read of 0x123, both requests low → ram_addr stays 0x123; disp_valid=0 and host_valid=0.
- Reset mid-operation: assert rst_n=0 in the cycle after a host_ack → host_valid never pulses; all outputs are at their reset values; normal operation resumes after release.
